// File: rtl/alu_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : alu_serial_frame_rx
// Brief   : Deserializes 10-bit din/enable_n words into ALU frames (args + cmd).
//           Optional macro ALU_RX_PARITY_CHECK_EN enables even-parity checking.
// Revision: 1.0 - initial release
// ============================================================================
module alu_serial_frame_rx #(
    parameter int MAX_ARGS = 10,
    localparam int CNT_W   = $clog2(MAX_ARGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  enable_n,
    input  logic                  frame_ready,
    output logic                  frame_valid,
    output logic [7:0]            frame_cmd,
    output logic [MAX_ARGS*8-1:0] frame_args,
    output logic [CNT_W-1:0]      frame_arg_cnt,
    output logic [3:0]            frame_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WORD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_ARGS);

    state_t                r_state;
    logic [9:0]            r_shift;
    logic [3:0]            r_bit_cnt;
    logic [MAX_ARGS*8-1:0] r_acc;
    logic [CNT_W-1:0]      r_acc_cnt;
    logic                  r_par_err;
    logic                  r_short_err;
    logic                  r_ovf_err;
    logic                  r_ovr_err;

    // r_shift[9] is b0 (type), [8:1] the payload MSB first, [0] the parity bit
    logic       w_is_cmd;
    logic [7:0] w_payload;
    logic       w_par_bad;
    logic       w_room;
    logic       w_load;

    assign w_is_cmd  = r_shift[9];
    assign w_payload = r_shift[8:1];
    assign w_room    = (r_acc_cnt < c_max_cnt);
    assign w_load    = !frame_valid || frame_ready;
`ifdef ALU_RX_PARITY_CHECK_EN
    assign w_par_bad = ^r_shift;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_acc         <= '0;
            r_acc_cnt     <= '0;
            r_par_err     <= 1'b0;
            r_short_err   <= 1'b0;
            r_ovf_err     <= 1'b0;
            r_ovr_err     <= 1'b0;
            frame_valid   <= 1'b0;
            frame_cmd     <= '0;
            frame_args    <= '0;
            frame_arg_cnt <= '0;
            frame_err     <= '0;
        end else begin
            if (frame_valid && frame_ready)
                frame_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!enable_n) begin
                        r_shift   <= {9'b0, din};
                        r_bit_cnt <= 4'd1;
                        r_state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!enable_n) begin
                        r_shift   <= {r_shift[8:0], din};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd9)
                            r_state <= S_WORD;
                    end else begin
                        r_short_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                S_WORD: begin
                    // A low enable_n here is already b0 of the next word
                    if (!enable_n) begin
                        r_shift   <= {9'b0, din};
                        r_bit_cnt <= 4'd1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state   <= S_IDLE;
                    end

                    if (!w_is_cmd) begin
                        if (w_room) begin
                            for (int i = 0; i < MAX_ARGS; i++) begin
                                if (r_acc_cnt == CNT_W'(i))
                                    r_acc[i*8 +: 8] <= w_payload;
                            end
                            r_acc_cnt <= r_acc_cnt + 1'b1;
                        end else begin
                            r_ovf_err <= 1'b1;
                        end
                        if (w_par_bad)
                            r_par_err <= 1'b1;
                    end else if (w_load) begin
                        frame_valid   <= 1'b1;
                        frame_cmd     <= w_payload;
                        frame_args    <= r_acc;
                        frame_arg_cnt <= r_acc_cnt;
                        frame_err     <= {r_ovr_err, r_short_err, r_ovf_err,
                                          r_par_err | w_par_bad};
                        r_acc         <= '0;
                        r_acc_cnt     <= '0;
                        r_par_err     <= 1'b0;
                        r_short_err   <= 1'b0;
                        r_ovf_err     <= 1'b0;
                        r_ovr_err     <= 1'b0;
                    end else begin
                        // Output still occupied: drop this frame, flag it on the next one
                        r_acc         <= '0;
                        r_acc_cnt     <= '0;
                        r_par_err     <= 1'b0;
                        r_short_err   <= 1'b0;
                        r_ovf_err     <= 1'b0;
                        r_ovr_err     <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_serial_frame_rx.md
Name: alu_serial_frame_rx

Overview:
- Serial input front end of the ALU DUT. It consumes the `din`/`enable_n` bit stream that the testbench BFM drives.
- It deserializes 10-bit words and sorts them into data and command words.
- It assembles a frame made of up to MAX_ARGS argument bytes followed by one command byte.
- It presents the completed frame to the ALU core over a valid/ready handshake, together with per-frame error flags.

Parameters:
- MAX_ARGS, 10, maximum number of data words accepted per frame.
- CNT_W, $clog2(MAX_ARGS+1), width of the argument count (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  1  serial data; sampled only while enable_n=0.
- enable_n  input  1  active-low word-enable; low for exactly 10 clocks per word.
- frame_ready  input  1  the core accepts the frame when frame_valid&&frame_ready.
- frame_valid  output  1  a completed frame is held on the frame_* outputs.
- frame_cmd  output  8  command payload.
- frame_args  output  MAX_ARGS*8  argument i occupies [i*8 +: 8]; arg 0 is the first received; unused slots are 0.
- frame_arg_cnt  output  CNT_W  number of valid args, saturating at MAX_ARGS.
- frame_err  output  4  error flags: [0] parity, [1] arg overflow, [2] short word, [3] overrun.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all outputs and internal state clear to 0. The FSM goes to IDLE. Reset mid-word or mid-frame discards all partial data.
- Word format, in transmit order (first bit first):
  - b0 = type (0 data, 1 command).
  - b1..b8 = payload, MSB first.
  - b9 = even parity over b0..b9. The total count of ones in the 10 bits is even.
- Bit FSM:
  - IDLE: on enable_n=0, sample din as b0, set bit_cnt=1, go to SHIFT.
  - SHIFT: while enable_n=0, shift din in and increment bit_cnt. The 10th sample (bit_cnt 9->10) completes the word and moves to WORD.
  - SHIFT short word: if enable_n=1 in SHIFT with bit_cnt in 1..9, discard the partial word, set sticky short_err, and go to IDLE.
  - WORD: one cycle spent processing the word, then return to IDLE. If enable_n=0 in this cycle, that sample is taken as b0 of the next word, so back-to-back words lose no bit.
- Data word processing:
  - If acc_cnt<MAX_ARGS: store the payload at slot acc_cnt and increment acc_cnt.
  - Otherwise: discard the payload and set sticky ovf_err.
- Command word processing:
  - The frame closes. Output registers load cmd, args, cnt and err = {overrun, short, ovf, parity}.
  - The load happens only if frame_valid=0, or if frame_valid&&frame_ready in this same cycle.
  - After a load, the accumulator and the sticky flags clear.
- Overrun: if the output is still occupied when a command word completes, the completed frame is dropped. The accumulator clears, and sticky overrun_err is set. It is reported on the next loaded frame.
- Latency: the 10th bit is sampled at edge N. The word is processed at edge N+1. frame_valid is high after edge N+1.
- Handshake:
  - frame_valid stays high and the frame_* outputs stay stable until frame_valid&&frame_ready.
  - frame_valid deasserts the next cycle, unless a new frame loads in that same cycle.
  - frame_ready has no effect while frame_valid=0.
- A command word with zero preceding args is legal: frame_arg_cnt=0 and frame_args=0.
- enable_n=1 in IDLE is a no-op; din is ignored.
- A parity error on a data word still stores the payload. A parity error on a command word still emits the frame with err[0]=1.

Optional Feature:
- Macro: ALU_RX_PARITY_CHECK_EN.
- Defined: b9 is checked as above, and parity failures set err[0].
- Undefined: b9 is ignored and frame_err[0] is tied to 0. All other behaviour is unchanged.

Test Plan:
- Args 0x12 then 0x34, then cmd 0x01, frame_ready=1 -> one frame_valid pulse with frame_args[15:0]=0x3412, cnt=2, cmd=0x01, err=0. Valid appears 1 cycle after the 10th cmd bit.
- 11 data words 0x00..0x0A, then cmd 0x02 -> cnt=10, args hold 0x00..0x09, err=4'b0010.
- Data word with enable_n raised after 6 bits, then a full arg 0x55 and cmd 0x03 -> cnt=1, arg0=0x55, err=4'b0100.
- Data 0x12 with b9 flipped, then cmd 0x04 -> err[0]=1 with the macro defined, err=0 without it. Arg0=0x12 in both cases.
- frame_ready=0, frame A (cmd 0x05), then frame B (cmd 0x06), then frame_ready pulsed, then frame C (cmd 0x07) -> A is held stable and B is dropped. C is then delivered with err[3]=1.
- rst_n=0 for 1 cycle after 5 bits of a word -> frame_valid=0, no frame emitted. The next clean frame carries err=0.
